fifo_packer: RTL and testbench



---
 rtl/fifo_packer.sv | 118 +++++++++++
 tb/tb_fifo_packer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_packer.sv
// fifo_packer: drains a first-word-fall-through FIFO and packs RATIO
// consecutive DATA_WIDTH-bit words into one wide word on a valid/ready
// stream. The accumulator and the one-entry output register are double
// buffered, so packing of the next word continues while the previous one
// waits for out_ready. A level flush emits a partial word with a slot mask
// once the FIFO has run dry. RATIO must be at least 2.
module fifo_packer #(
    parameter int DATA_WIDTH = 2,
    parameter int RATIO      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_WIDTH-1:0]       fifo_dout,
    input  logic                        fifo_empty,
    output logic                        fifo_pop,
    input  logic                        flush,
    output logic [DATA_WIDTH*RATIO-1:0] out_data,
    output logic [RATIO-1:0]            out_mask,
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam int OUT_W = DATA_WIDTH * RATIO;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    // Packing state
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // Output register
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic [RATIO-1:0] out_mask_q, out_mask_d;
    logic             out_valid_q, out_valid_d;

    // Derived control
    logic             out_free;
    logic             last_slot;
    logic             flush_emit;
    logic [OUT_W-1:0] acc_with_head;
    logic [RATIO-1:0] fill_mask;

    // Accumulator with the FIFO head merged into the current slot, and the
    // mask of slots already filled (slots below idx).
    genvar gi;
    generate
        for (gi = 0; gi < RATIO; gi++) begin : g_slot
            assign acc_with_head[gi*DATA_WIDTH +: DATA_WIDTH] =
                (idx_q == IDX_W'(gi)) ? fifo_dout
                                      : acc_q[gi*DATA_WIDTH +: DATA_WIDTH];
            assign fill_mask[gi] = (IDX_W'(gi) < idx_q);
        end
    endgenerate

    // The output register can take a new word if it is empty or being
    // drained on this same edge. Only the final slot needs that room; the
    // lower slots keep filling under backpressure.
    assign out_free   = !out_valid_q || out_ready;
    assign last_slot  = (idx_q == LAST_IDX);
    assign fifo_pop   = !rst && !fifo_empty && (!last_slot || out_free);
    assign flush_emit = flush && fifo_empty && (idx_q != '0) && out_free;

    // Next-state: slot fill, full-word load, flush emission and drain
    always_comb begin
        acc_d       = acc_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        out_mask_d  = out_mask_q;
        out_valid_d = out_valid_q;

        // Drain first; a load on the same edge overrides it (no bubble).
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (fifo_pop) begin
            if (last_slot) begin
                out_data_d  = acc_with_head;
                out_mask_d  = '1;
                out_valid_d = 1'b1;
                acc_d       = '0;
                idx_d       = '0;
            end else begin
                acc_d = acc_with_head;
                idx_d = idx_q + IDX_W'(1);
            end
        end else if (flush_emit) begin
            // Unfilled slots are already zero because acc clears on emit.
            out_data_d  = acc_q;
            out_mask_d  = fill_mask;
            out_valid_d = 1'b1;
            acc_d       = '0;
            idx_d       = '0;
        end
    end

    // State registers with synchronous reset; reset drops any partial word
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_mask_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_mask_q  <= out_mask_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_mask  = out_mask_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fifo_packer.sv
// tb_fifo_packer: directed scenarios plus randomized traffic for fifo_packer,
// checked cycle by cycle against a queue-based reference model.
module tb_fifo_packer;

    localparam int DW = 2;
    localparam int R  = 4;
    localparam int OW = DW * R;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] fifo_dout = '0;
    logic          fifo_empty = 1'b1;
    logic          fifo_pop;
    logic          flush = 1'b0;
    logic [OW-1:0] out_data;
    logic [R-1:0]  out_mask;
    logic          out_valid;
    logic          out_ready = 1'b0;

    fifo_packer #(.DATA_WIDTH(DW), .RATIO(R)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_pop   (fifo_pop),
        .flush      (flush),
        .out_data   (out_data),
        .out_mask   (out_mask),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Idealised FIFO feeding the DUT
    logic [DW-1:0] fq[$];

    // Reference model: words collected toward the next output, and the
    // output register contents.
    logic [DW-1:0] pend[$];
    bit            mv;
    logic [OW-1:0] md;
    logic [R-1:0]  mm;
    bit            zeroed;

    // Words accepted downstream, as seen on the DUT outputs
    logic [OW-1:0] log_d[$];
    logic [R-1:0]  log_m[$];
    int            pops;
    int            valid_cycles;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [OW-1:0] pack_pend();
        logic [OW-1:0] r;
        r = '0;
        for (int i = 0; i < pend.size(); i++)
            r = r | (OW'(pend[i]) << (DW * i));
        return r;
    endfunction

    task automatic push(input logic [DW-1:0] w);
        fq.push_back(w);
    endtask

    // One clock cycle: drive inputs, check outputs against the model,
    // advance the model, then let the edge happen.
    task automatic step(input bit r, input bit fl, input bit rdy);
        bit empty, free, exp_pop, consume, pop_seen;
        @(negedge clk);
        rst       = r;
        flush     = fl;
        out_ready = rdy;
        empty     = (fq.size() == 0);
        fifo_empty = empty;
        fifo_dout  = empty ? DW'($urandom) : fq[0];
        #1;
        free    = !mv || rdy;
        exp_pop = !r && !empty && ((pend.size() != R - 1) || free);
        chk("pop", fifo_pop, exp_pop);
        chk("valid", out_valid, mv);
        if (mv || zeroed) begin
            chk("data", out_data, md);
            chk("mask", out_mask, mm);
        end
        pop_seen = fifo_pop;
        if (fifo_pop) pops++;
        if (out_valid) valid_cycles++;
        consume = !r && mv && rdy;
        if (consume) begin
            log_d.push_back(out_data);
            log_m.push_back(out_mask);
            $display("accept data=%h mask=%b t=%0t", out_data, out_mask, $time);
        end

        if (r) begin
            pend.delete();
            mv = 0; md = '0; mm = '0; zeroed = 1;
        end else if (exp_pop) begin
            pend.push_back(fq[0]);
            if (pend.size() == R) begin
                md = pack_pend(); mm = '1; mv = 1; zeroed = 0;
                pend.delete();
            end else if (consume) begin
                mv = 0;
            end
        end else if (fl && empty && pend.size() != 0 && free) begin
            md = pack_pend();
            mm = R'((1 << pend.size()) - 1);
            mv = 1; zeroed = 0;
            pend.delete();
        end else if (consume) begin
            mv = 0;
        end

        @(posedge clk);
        if (pop_seen && fq.size() > 0) void'(fq.pop_front());
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        mv = 0; md = '0; mm = '0; zeroed = 1;

        // Reset held with data waiting in the FIFO: no pops.
        push(2'd1); push(2'd2); push(2'd3); push(2'd0);
        pops = 0;
        step(1, 0, 1);
        step(1, 0, 1);
        chk("rst_pops", pops, 0);

        // Basic pack of 1,2,3,0.
        log_d.delete(); log_m.delete();
        pops = 0; valid_cycles = 0;
        repeat (8) step(0, 0, 1);
        chk("pack_pops", pops, 4);
        chk("pack_vcyc", valid_cycles, 1);
        chk("pack_n", log_d.size(), 1);
        if (log_d.size() >= 1) begin
            chk("pack_data", log_d[0], 8'h39);
            chk("pack_mask", log_m[0], 4'b1111);
        end

        // Backpressure: 7 pops then stall on the last slot.
        log_d.delete(); log_m.delete();
        repeat (4) push(2'd1);
        repeat (4) push(2'd2);
        pops = 0;
        repeat (12) step(0, 0, 0);
        chk("bp_pops", pops, 7);
        chk("bp_held_n", log_d.size(), 0);
        chk("bp_held_data", out_data, 8'h55);
        valid_cycles = 0;
        repeat (6) step(0, 0, 1);
        chk("bp_vcyc", valid_cycles, 2);
        chk("bp_n", log_d.size(), 2);
        if (log_d.size() >= 2) begin
            chk("bp_data0", log_d[0], 8'h55);
            chk("bp_data1", log_d[1], 8'hAA);
        end

        // Flush of a partial word 3,1.
        log_d.delete(); log_m.delete();
        push(2'd3); push(2'd1);
        repeat (6) step(0, 1, 1);
        chk("fl_n", log_d.size(), 1);
        if (log_d.size() >= 1) begin
            chk("fl_data", log_d[0], 8'h07);
            chk("fl_mask", log_m[0], 4'b0011);
        end
        // Slot index back at 0: a fresh full word lands in slot order.
        log_d.delete(); log_m.delete();
        push(2'd1); push(2'd2); push(2'd3); push(2'd0);
        repeat (7) step(0, 0, 1);
        chk("fl_after_n", log_d.size(), 1);
        if (log_d.size() >= 1) chk("fl_after_data", log_d[0], 8'h39);

        // Flush with nothing accumulated and the FIFO empty: no output.
        valid_cycles = 0;
        repeat (5) step(0, 1, 1);
        chk("noop_vcyc", valid_cycles, 0);

        // Reset mid-pack discards the partial word.
        push(2'd3); push(2'd3);
        step(0, 0, 1);
        step(0, 0, 1);
        step(1, 0, 1);
        log_d.delete(); log_m.delete();
        push(2'd0); push(2'd1); push(2'd2); push(2'd3);
        repeat (7) step(0, 0, 1);
        chk("rmid_n", log_d.size(), 1);
        if (log_d.size() >= 1) begin
            chk("rmid_data", log_d[0], 8'hE4);
            chk("rmid_mask", log_m[0], 4'b1111);
        end

        // Randomized traffic with occasional flush and rare reset.
        for (int i = 0; i < 600; i++) begin
            if (($urandom % 3) != 0 && fq.size() < 16) push(DW'($urandom));
            step(($urandom % 97) == 0, ($urandom % 5) == 0, ($urandom % 3) != 0);
        end
        repeat (30) step(0, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
